ram_arbiter: RTL and testbench

Sequencing controller and two-port arbiter for the 256×16 data RAM. It shares the single RAM port between the instruction-fetch unit (read-only) and the load/store unit (read/write). Selection is round-robin, and every RAM access runs through a fixed three-state sequence. The block sits between the CPU core and the RAM, and it is the only driver of the RAM's address, write-data and write-enable inputs.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 17 +
 rtl/ram_arbiter.sv | 112 +++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM sequencer/arbiter.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 16;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant
);

  always_comb begin
    o_grant = PORT_F;
    if (i_req == 2'b11) o_grant = ~i_last_grant;
    else if (i_req[PORT_D]) o_grant = PORT_D;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between fetch (read-only) and load/store,
// running each access through IDLE -> ISSUE -> DONE with registered outputs.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_ack,
  output logic [DATA_W-1:0] o_f_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_busy
);

  state_t            r_state;
  logic              r_last;
  logic              r_win;
  logic              r_we;
  logic              r_busy;
  logic              r_f_ack;
  logic              r_d_ack;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic [1:0] w_req;
  logic       w_grant;
  logic       w_store;

  assign w_req   = {i_d_req, i_f_req};
  assign w_store = (w_grant == PORT_D) && i_d_we;

  rr_arbiter2 u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last),
    .o_grant      (w_grant)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_last    <= PORT_D;
      r_win     <= PORT_F;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_f_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_f_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_win   <= w_grant;
            r_last  <= w_grant;
            r_addr  <= (w_grant == PORT_D) ? i_d_addr : i_f_addr;
            if (w_store) r_din <= i_d_wdata;
            // we is raised here so it is high for exactly the ISSUE cycle
            r_we    <= w_store;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_we    <= 1'b0;
          r_state <= DONE;
        end
        DONE: begin
          // RAM re-reads after we falls, so a store captures the new word
          if (r_win == PORT_D) begin
            r_d_rdata <= i_ram_dout;
            r_d_ack   <= 1'b1;
          end else begin
            r_f_rdata <= i_ram_dout;
            r_f_ack   <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_f_ack    = r_f_ack;
  assign o_f_rdata  = r_f_rdata;
  assign o_d_ack    = r_d_ack;
  assign o_d_rdata  = r_d_rdata;
  assign o_ram_addr = r_addr;
  assign o_ram_din  = r_din;
  assign o_ram_we   = r_we;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: requester drivers push expected read data,
// a forked monitor pops and compares on every ack.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [7:0]  f_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        f_ack, d_ack, ram_we, busy;
  logic [15:0] f_rdata, d_rdata, ram_din, ram_dout;
  logic [7:0]  ram_addr;

  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] ram     [256];
  logic [15:0] ref_mem [256];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int we_cnt = 0;
  int st_cnt = 0;
  bit we_prev = 0, fa_prev = 0, da_prev = 0;
  bit busy_log [0:16383];
  logic [15:0] f_exp [$];
  logic [15:0] d_exp [$];
  int ack_port [$];
  int ack_cyc  [$];

  always #5 clk = ~clk;

  // Simple RAM: synchronous write, combinational read
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_we) ram[ram_addr] <= ram_din;
  end
  assign ram_dout = ram[ram_addr];

  ram_arbiter dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_f_req    (f_req),
    .i_f_addr   (f_addr),
    .o_f_ack    (f_ack),
    .o_f_rdata  (f_rdata),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .o_d_ack    (d_ack),
    .o_d_rdata  (d_rdata),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .o_ram_we   (ram_we),
    .i_ram_dout (ram_dout),
    .o_busy     (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_f_ack"},    f_ack,    0);
    chk({tag, "_d_ack"},    d_ack,    0);
    chk({tag, "_ram_we"},   ram_we,   0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"},  ram_din,  0);
    chk({tag, "_f_rdata"},  f_rdata,  0);
    chk({tag, "_d_rdata"},  d_rdata,  0);
  endtask

  // exact=1: latency must equal lat; exact=0: wait must not exceed lat
  task automatic do_fetch(input logic [7:0] a, input int lat, input bit exact);
    int n = 0;
    f_exp.push_back(ref_mem[a]);
    f_addr = a;
    f_req  = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!f_ack && n < 30);
    if (!f_ack) begin
      compared++; mismatched++;
      $display("FAIL f_timeout: no f_ack within %0d cycles, addr 0x%0h", n, a);
    end else if (exact) chk("f_latency", n, lat);
    else chk("f_wait_bound", (n <= lat), 1);
    f_req = 1'b0;
    wait_cycles(1);
  endtask

  task automatic do_data(input bit we, input logic [7:0] a, input logic [15:0] wd,
                         input int lat, input bit exact);
    int n = 0;
    if (we) begin ref_mem[a] = wd; st_cnt++; end
    d_exp.push_back(ref_mem[a]);
    d_we = we; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!d_ack && n < 30);
    if (!d_ack) begin
      compared++; mismatched++;
      $display("FAIL d_timeout: no d_ack within %0d cycles, addr 0x%0h", n, a);
    end else if (exact) chk("d_latency", n, lat);
    else chk("d_wait_bound", (n <= lat), 1);
    d_req = 1'b0;
    d_we  = 1'b0;
    wait_cycles(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          cyc++;
          busy_log[cyc & 16383] = busy;
          if (f_ack || d_ack) chk("ack_overlap", f_ack & d_ack, 0);
          if (f_ack) begin
            chk("f_ack_pulse", fa_prev, 0);
            if (f_exp.size() == 0) begin
              compared++; mismatched++;
              $display("FAIL f_unexpected_ack: got ack with rdata 0x%0h, want no ack", f_rdata);
            end else chk("f_rdata", f_rdata, f_exp.pop_front());
            ack_port.push_back(0); ack_cyc.push_back(cyc);
          end
          if (d_ack) begin
            chk("d_ack_pulse", da_prev, 0);
            if (d_exp.size() == 0) begin
              compared++; mismatched++;
              $display("FAIL d_unexpected_ack: got ack with rdata 0x%0h, want no ack", d_rdata);
            end else chk("d_rdata", d_rdata, d_exp.pop_front());
            ack_port.push_back(1); ack_cyc.push_back(cyc);
          end
          if (ram_we) begin
            we_cnt++;
            chk("we_single_cycle", we_prev, 0);
            chk("we_while_busy", busy, 1);
            chk("we_only_for_store", d_req & d_we, 1);
          end
          we_prev = ram_we; fa_prev = f_ack; da_prev = d_ack;
        end
      end
      begin : stimulus
        int base;
        logic [7:0] a;
        bit w;
        // preload RAM and reference with random contents, 0xBEEF at 0x10
        for (int i = 0; i < 256; i++) begin
          pre_addr = 8'(i);
          pre_data = (i == 16) ? 16'hBEEF : 16'($urandom);
          ref_mem[i] = pre_data;
          pre_we = 1'b1;
          wait_cycles(1);
        end
        pre_we = 1'b0;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        // lone fetch
        do_fetch(8'h10, 3, 1);
        // store then load at top address
        do_data(1'b1, 8'hFF, 16'h1234, 3, 1);
        do_data(1'b0, 8'hFF, 16'h0000, 3, 1);

        // fresh reset, then simultaneous requests: fetch wins the first tie
        rst_n = 1'b0; wait_cycles(1); rst_n = 1'b1; wait_cycles(1);
        base = ack_port.size();
        fork
          do_fetch(8'h20, 3, 1);
          do_data(1'b0, 8'h30, 16'h0000, 6, 1);
        join
        chk("tie_first_port", ack_port[base], 0);
        chk("tie_ack_spacing", ack_cyc[base+1] - ack_cyc[base], 3);

        // sustained contention over 8 accesses
        base = ack_port.size();
        fork
          repeat (4) do_fetch(8'($urandom_range(0, 127)), 6, 0);
          repeat (4) do_data(1'b0, 8'($urandom_range(0, 255)), 16'h0000, 6, 0);
        join
        for (int i = 0; i < 8; i++) chk("contention_order", ack_port[base+i], i % 2);
        for (int i = 1; i < 8; i++)
          chk("contention_spacing", ack_cyc[base+i] - ack_cyc[base+i-1], 3);
        for (int c = ack_cyc[base]; c <= ack_cyc[base+7]; c++)
          chk("contention_busy", busy_log[c & 16383], ((c - ack_cyc[base]) % 3) != 0);

        // both ends of the address space
        do_data(1'b0, 8'h00, 16'h0000, 3, 1);
        do_data(1'b0, 8'hFF, 16'h0000, 3, 1);
        do_fetch(8'hFF, 3, 1);
        do_fetch(8'h00, 3, 1);

        // reset during ISSUE of a store
        d_we = 1'b1; d_addr = 8'h80; d_wdata = 16'hA5A5; d_req = 1'b1;
        wait_cycles(1);
        chk("abort_we_in_issue", ram_we, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        d_req = 1'b0; d_we = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(1);
        do_data(1'b1, 8'h80, 16'h5A5A, 3, 1);
        do_data(1'b0, 8'h80, 16'h0000, 3, 1);

        // randomized concurrent traffic; stores stay above 0x7F, fetches below
        fork
          repeat (40) begin
            wait_cycles($urandom_range(0, 3));
            do_fetch(8'($urandom_range(0, 127)), 6, 0);
          end
          repeat (40) begin
            wait_cycles($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = w ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 255));
            do_data(w, a, 16'($urandom), 6, 0);
          end
        join

        wait_cycles(4);
        chk("f_queue_drained", f_exp.size(), 0);
        chk("d_queue_drained", d_exp.size(), 0);
        chk("we_cycles_per_store", we_cnt, st_cnt);
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
